uart_xcvr: RTL and testbench

Runtime-configurable full-duplex UART transceiver that generalises the fixed-format UART top into one block: frame format and baud rate are selectable at run time. It supports a configurable data width, optional even/odd parity, 1 or 2 stop bits, and a runtime baud divisor. Error reporting covers parity, framing and overrun. It sits between a byte-stream producer/consumer (valid/ready) and the board-level txd/rxd pins.

---
 rtl/uart_xcvr_if.sv | 27 ++
 rtl/uart_xcvr.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_xcvr_if.sv
// Byte-stream side of the UART transceiver: TX and RX valid/ready channels.
// The producer/consumer holds the master modport, the transceiver the slave.
interface uart_xcvr_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rx_parity_err;
  logic                  rx_frame_err;
  logic                  rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid,
    input  rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid,
    output rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_xcvr.sv
// Full-duplex UART with runtime divisor, parity mode and stop-bit count.
// Each direction latches its frame format when its frame begins.
module uart_xcvr #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 txd,
  input  logic                 rxd,
  uart_xcvr_if.slave           bus
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef logic [DIV_WIDTH-1:0] div_t;
  typedef logic [BW-1:0] bit_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  localparam div_t D1    = div_t'(1);
  localparam bit_t B1    = bit_t'(1);
  localparam bit_t BLAST = bit_t'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  div_t div_eff;
  logic par_en;
  assign div_eff = (cfg_div < div_t'(4)) ? div_t'(4) : cfg_div;
  assign par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);

  st_t   t_st, t_st_n;
  div_t  t_cnt, t_cnt_n, t_div, t_div_n;
  bit_t  t_bit, t_bit_n;
  word_t t_sh, t_sh_n;
  logic  t_par, t_par_n, t_pen, t_pen_n;
  logic  t_s2, t_s2_n, t_txd, t_txd_n;

  assign txd          = t_txd;
  assign bus.tx_ready = (t_st == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_st  <= S_IDLE;
      t_cnt <= '0;
      t_div <= div_t'(4);
      t_bit <= '0;
      t_sh  <= '0;
      t_par <= 1'b0;
      t_pen <= 1'b0;
      t_s2  <= 1'b0;
      t_txd <= 1'b1;
    end else begin
      t_st  <= t_st_n;
      t_cnt <= t_cnt_n;
      t_div <= t_div_n;
      t_bit <= t_bit_n;
      t_sh  <= t_sh_n;
      t_par <= t_par_n;
      t_pen <= t_pen_n;
      t_s2  <= t_s2_n;
      t_txd <= t_txd_n;
    end
  end

  always_comb begin
    t_st_n  = t_st;
    t_cnt_n = t_cnt;
    t_div_n = t_div;
    t_bit_n = t_bit;
    t_sh_n  = t_sh;
    t_par_n = t_par;
    t_pen_n = t_pen;
    t_s2_n  = t_s2;
    t_txd_n = t_txd;
    if (t_st != S_IDLE) t_cnt_n = t_cnt - D1;
    unique case (t_st)
      S_IDLE: begin
        t_txd_n = 1'b1;
        if (bus.tx_valid) begin
          t_st_n  = S_START;
          t_txd_n = 1'b0;
          t_cnt_n = div_eff - D1;
          t_div_n = div_eff;
          t_pen_n = par_en;
          t_s2_n  = cfg_stop2;
          t_sh_n  = bus.tx_data;
          t_par_n = (^bus.tx_data) ^ cfg_parity[1];
        end
      end
      S_START: if (t_cnt == '0) begin
        t_st_n  = S_DATA;
        t_txd_n = t_sh[0];
        t_cnt_n = t_div - D1;
        t_bit_n = BLAST;
      end
      S_DATA: if (t_cnt == '0) begin
        t_cnt_n = t_div - D1;
        if (t_bit == '0) begin
          t_st_n  = t_pen ? S_PAR : S_STOP;
          t_txd_n = t_pen ? t_par : 1'b1;
          t_bit_n = t_s2 ? B1 : '0;
        end else begin
          t_bit_n = t_bit - B1;
          t_sh_n  = t_sh >> 1;
          t_txd_n = t_sh[1];
        end
      end
      S_PAR: if (t_cnt == '0) begin
        t_st_n  = S_STOP;
        t_txd_n = 1'b1;
        t_cnt_n = t_div - D1;
      end
      S_STOP: if (t_cnt == '0) begin
        t_cnt_n = t_div - D1;
        if (t_bit == '0) t_st_n = S_IDLE;
        else t_bit_n = t_bit - B1;
      end
      default: t_st_n = S_IDLE;
    endcase
  end

  // s3 holds the previous synchronized level for falling-edge detection
  logic  s1, s2, s3;
  st_t   r_st, r_st_n;
  div_t  r_cnt, r_cnt_n, r_div, r_div_n;
  bit_t  r_bit, r_bit_n;
  word_t r_sh, r_sh_n;
  logic  r_pen, r_pen_n, r_odd, r_odd_n, r_pe, r_pe_n;
  logic  done, fe;
  word_t o_data;
  logic  o_valid, o_pe, o_fe, o_ov, hs;

  assign bus.rx_data       = o_data;
  assign bus.rx_valid      = o_valid;
  assign bus.rx_parity_err = o_pe;
  assign bus.rx_frame_err  = o_fe;
  assign bus.rx_overrun    = o_ov;
  assign hs = o_valid && bus.rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s3    <= 1'b1;
      r_st  <= S_IDLE;
      r_cnt <= '0;
      r_div <= div_t'(4);
      r_bit <= '0;
      r_sh  <= '0;
      r_pen <= 1'b0;
      r_odd <= 1'b0;
      r_pe  <= 1'b0;
    end else begin
      s1    <= rxd;
      s2    <= s1;
      s3    <= s2;
      r_st  <= r_st_n;
      r_cnt <= r_cnt_n;
      r_div <= r_div_n;
      r_bit <= r_bit_n;
      r_sh  <= r_sh_n;
      r_pen <= r_pen_n;
      r_odd <= r_odd_n;
      r_pe  <= r_pe_n;
    end
  end

  always_comb begin
    r_st_n  = r_st;
    r_cnt_n = r_cnt;
    r_div_n = r_div;
    r_bit_n = r_bit;
    r_sh_n  = r_sh;
    r_pen_n = r_pen;
    r_odd_n = r_odd;
    r_pe_n  = r_pe;
    done    = 1'b0;
    fe      = 1'b0;
    if (r_st != S_IDLE) r_cnt_n = r_cnt - D1;
    unique case (r_st)
      S_IDLE: if (s3 && !s2) begin
        r_st_n  = S_START;
        r_cnt_n = (div_eff >> 1) - D1;
        r_div_n = div_eff;
        r_pen_n = par_en;
        r_odd_n = cfg_parity[1];
        r_pe_n  = 1'b0;
      end
      S_START: if (r_cnt == '0) begin
        r_cnt_n = r_div - D1;
        r_bit_n = BLAST;
        r_st_n  = s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (r_cnt == '0) begin
        r_sh_n  = {s2, r_sh[DATA_WIDTH-1:1]};
        r_cnt_n = r_div - D1;
        if (r_bit == '0) r_st_n = r_pen ? S_PAR : S_STOP;
        else r_bit_n = r_bit - B1;
      end
      S_PAR: if (r_cnt == '0) begin
        r_pe_n  = s2 ^ (^r_sh) ^ r_odd;
        r_cnt_n = r_div - D1;
        r_st_n  = S_STOP;
      end
      S_STOP: if (r_cnt == '0) begin
        done   = 1'b1;
        fe     = !s2;
        r_st_n = S_IDLE;
      end
      default: r_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_pe    <= 1'b0;
      o_fe    <= 1'b0;
      o_ov    <= 1'b0;
    end else if (done && (!o_valid || hs)) begin
      o_data  <= r_sh;
      o_valid <= 1'b1;
      o_pe    <= r_pe;
      o_fe    <= fe;
      o_ov    <= 1'b0;
    end else if (done) begin
      o_ov <= 1'b1;
    end else if (hs) begin
      o_valid <= 1'b0;
      o_pe    <= 1'b0;
      o_fe    <= 1'b0;
      o_ov    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: TX framing, loopback, RX error flags,
// overrun, false start, mid-frame reset and divisor clamping.
module tb_uart_xcvr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = 16'd8;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        txd, rxd;
  logic        rxd_drv = 1'b1;
  logic        lb = 1'b0;
  int          checks = 0;
  int          errors = 0;

  uart_xcvr_if #(.DATA_WIDTH(8)) bus ();

  assign rxd = lb ? txd : rxd_drv;

  uart_xcvr #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_div(cfg_div),
    .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
    .txd(txd),
    .rxd(rxd),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rxv(input string tag);
    int i = 0;
    while (!bus.rx_valid && i < 400) begin
      cyc(1);
      i++;
    end
    chk(tag, bus.rx_valid, 1'b1);
  endtask

  task automatic wait_txr(input string tag);
    int i = 0;
    while (!bus.tx_ready && i < 400) begin
      cyc(1);
      i++;
    end
    chk(tag, bus.tx_ready, 1'b1);
  endtask

  task automatic ack();
    bus.rx_ready = 1'b1;
    cyc(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input bit pen, input bit pb,
                         input bit sb, input int div);
    rxd_drv = 1'b0;
    cyc(div);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      cyc(div);
    end
    if (pen) begin
      rxd_drv = pb;
      cyc(div);
    end
    rxd_drv = sb;
    cyc(div);
    rxd_drv = 1'b1;
    cyc(div);
  endtask

  initial begin
    logic [9:0]  fr;
    logic [79:0] obs80, exp80;
    logic [39:0] obs40, exp40;
    logic        par, seen;
    int          low;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    cyc(1);
    chk("rst_txd", txd, 1'b1);
    chk("rst_tx_ready", bus.tx_ready, 1'b0);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_flags", {bus.rx_parity_err, bus.rx_frame_err,
                      bus.rx_overrun}, 3'b000);
    rst = 1'b0;
    cyc(1);
    chk("ready_after_rst", bus.tx_ready, 1'b1);

    // TX framing: 0xA5, div 8, 8N1
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 80; k++) exp80[k] = fr[k / 8];
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    chk("tx_ready_drop", bus.tx_ready, 1'b0);
    obs80 = '0;
    for (int k = 1; k <= 80; k++) begin
      obs80[k-1] = txd;
      if (k < 80) cyc(1);
    end
    chk("tx_frame_a5", obs80, exp80);
    chk("tx_ready_c80", bus.tx_ready, 1'b0);
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    cyc(1);
    chk("tx_ready_c81", bus.tx_ready, 1'b1);
    chk("txd_c81", txd, 1'b1);
    cyc(1);
    bus.tx_valid = 1'b0;
    chk("b2b_start", txd, 1'b0);
    chk("b2b_busy", bus.tx_ready, 1'b0);
    wait_txr("b2b_done");

    // Loopback 8E2, config changed mid-frame
    cfg_div    = 16'd16;
    cfg_parity = 2'b01;
    cfg_stop2  = 1'b1;
    lb         = 1'b1;
    bus.tx_data  = 8'h37;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    low = 0;
    par = 1'b0;
    for (int c = 1; c <= 260; c++) begin
      if (c == 5) begin
        cfg_div    = 16'd8;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
      end
      if (c == 152) par = txd;
      if (!bus.tx_ready) low++;
      cyc(1);
    end
    chk("lb_tx_len", low, 192);
    chk("lb_parity_bit", par, 1'b1);
    chk("lb_rx_valid", bus.rx_valid, 1'b1);
    chk("lb_rx_data", bus.rx_data, 8'h37);
    chk("lb_flags", {bus.rx_parity_err, bus.rx_frame_err,
                     bus.rx_overrun}, 3'b000);
    ack();
    chk("lb_ack", bus.rx_valid, 1'b0);
    lb = 1'b0;

    // Error flags, odd parity
    cfg_div    = 16'd8;
    cfg_parity = 2'b10;
    send_rx(8'h0F, 1'b1, 1'b0, 1'b1, 8);
    wait_rxv("pe_valid");
    chk("pe_data", bus.rx_data, 8'h0F);
    chk("pe_flag", bus.rx_parity_err, 1'b1);
    chk("pe_fe", bus.rx_frame_err, 1'b0);
    ack();
    chk("pe_cleared", {bus.rx_valid, bus.rx_parity_err}, 2'b00);
    send_rx(8'h55, 1'b1, 1'b1, 1'b0, 8);
    wait_rxv("fe_valid");
    chk("fe_data", bus.rx_data, 8'h55);
    chk("fe_flag", bus.rx_frame_err, 1'b1);
    chk("fe_pe", bus.rx_parity_err, 1'b0);
    ack();

    // Overrun with rx_ready held low
    cfg_parity = 2'b00;
    send_rx(8'h11, 1'b0, 1'b0, 1'b1, 8);
    wait_rxv("ov_first");
    send_rx(8'h22, 1'b0, 1'b0, 1'b1, 8);
    chk("ov_hold_data", bus.rx_data, 8'h11);
    chk("ov_flag", {bus.rx_valid, bus.rx_overrun}, 2'b11);
    send_rx(8'h33, 1'b0, 1'b0, 1'b1, 8);
    chk("ov_hold_data3", bus.rx_data, 8'h11);
    ack();
    chk("ov_ack", {bus.rx_valid, bus.rx_overrun}, 2'b00);
    send_rx(8'h44, 1'b0, 1'b0, 1'b1, 8);
    wait_rxv("ov_fourth");
    chk("ov_fourth_data", bus.rx_data, 8'h44);
    chk("ov_fourth_flags", {bus.rx_parity_err, bus.rx_frame_err,
                            bus.rx_overrun}, 3'b000);
    ack();

    // False start: 2-cycle glitch at div 16
    cfg_div = 16'd16;
    rxd_drv = 1'b0;
    cyc(2);
    rxd_drv = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.rx_valid) seen = 1'b1;
      cyc(1);
    end
    chk("glitch_no_valid", seen, 1'b0);
    send_rx(8'hC3, 1'b0, 1'b0, 1'b1, 16);
    wait_rxv("c3_valid");
    chk("c3_data", bus.rx_data, 8'hC3);
    chk("c3_fe", bus.rx_frame_err, 1'b0);
    ack();

    // Reset in the middle of TX bit 3 and an RX frame
    cfg_div = 16'd8;
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    rxd_drv      = 1'b0;
    cyc(1);
    bus.tx_valid = 1'b0;
    cyc(34);
    chk("mid_bit3", txd, 1'b0);
    rst     = 1'b1;
    rxd_drv = 1'b1;
    cyc(1);
    chk("rst_mid_txd", txd, 1'b1);
    chk("rst_mid_ready", bus.tx_ready, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("rst_mid_ready_after", bus.tx_ready, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.rx_valid) seen = 1'b1;
      cyc(1);
    end
    chk("rst_rx_discard", seen, 1'b0);

    // cfg_div 2 is clamped to 4
    cfg_div = 16'd2;
    lb      = 1'b1;
    for (int k = 0; k < 40; k++) exp40[k] = fr[k / 4];
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    obs40 = '0;
    for (int k = 1; k <= 40; k++) begin
      obs40[k-1] = txd;
      cyc(1);
    end
    chk("div2_frame", obs40, exp40);
    chk("div2_ready", bus.tx_ready, 1'b1);
    wait_rxv("div2_rx_valid");
    chk("div2_rx_data", bus.rx_data, 8'hA5);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
